// File: rtl/fifo_rd_stream.sv
// Read-side controller: pops a one-cycle-latency FIFO into a 2-entry buffer exposed as a valid/ready stream.
// Optional accepted-byte counter on pop_count is enabled by defining FIFO_RD_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pop_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              state_q, state_d;
    logic              inflight_q;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    logic              accept;
    logic [1:0]        occ;
    logic [1:0]        afterAccept;
    logic [1:0]        committed;

    assign occ     = state_q;
    assign m_valid = (state_q != EMPTY);
    assign m_data  = head_q;
    assign busy    = m_valid | inflight_q;
    assign accept  = m_valid & m_ready;

    // committed counts slots already spoken for; a pop is only allowed if one stays free for it.
    always_comb begin
        afterAccept = occ - {1'b0, accept};
        committed   = afterAccept + {1'b0, inflight_q};
        fifo_rd_en  = rst_n & ena & ~fifo_empty & (committed <= 2'd1);
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        unique case (committed)
            2'd0:    state_d = EMPTY;
            2'd1:    state_d = ONE;
            default: state_d = TWO;
        endcase

        if (accept) begin
            head_d = tail_q;
        end

        // The returning byte lands in whichever slot is first free once the accept has shifted the buffer.
        if (inflight_q) begin
            if (afterAccept == 2'd0) begin
                head_d = fifo_rd_data;
            end else begin
                tail_d = fifo_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pop_count = cnt_q;
`else
    assign pop_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: bytes pushed into a FIFO model are expected on the stream in order.
// Directed timing checks cover latency, backpressure, ena gating and asynchronous reset.
module tb_fifo_rd_stream;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       busy;
    logic [7:0] pop_count;

    logic [7:0] mem [0:511];
    int         rdPtr = 0;
    int         wrPtr = 0;
    int         popCount = 0;
    logic [7:0] expQ [$];

    int compared = 0;
    int mismatched = 0;
    int acceptTotal = 0;
    int acceptSinceReset = 0;
    logic       prevHold = 1'b0;
    logic [7:0] prevData = 8'h00;

    fifo_rd_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .busy         (busy),
        .pop_count    (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (rdPtr == wrPtr);

    // FIFO model: one-cycle read latency.
    initial fifo_rd_data = 8'h00;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rdPtr];
            rdPtr        <= rdPtr + 1;
            popCount     <= popCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        mem[wrPtr] = b;
        wrPtr = wrPtr + 1;
        expQ.push_back(b);
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_done", expQ.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every accept and checks output stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevHold = 1'b0;
            acceptSinceReset = 0;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", m_valid, 1);
                checkOutput("hold_data", m_data, prevData);
            end
            if (m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_byte", m_data, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("stream_data", m_data, expQ.pop_front());
                end
                acceptTotal++;
                acceptSinceReset++;
            end
            prevHold = m_valid && !m_ready;
            prevData = m_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int win;
        int p0;
        rst_n   = 1'b0;
        ena     = 1'b0;
        m_ready = 1'b0;
        #12;
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        checkOutput("rst_m_data", m_data, 8'h00);
        checkOutput("rst_pop_count", pop_count, 8'h00);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Test 1: three bytes, m_ready high; latency and busy profile
        @(posedge clk); #1;
        ena = 1'b1;
        m_ready = 1'b1;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_rd_en_c%0d", i), fifo_rd_en, (i <= 2) ? 1 : 0);
            checkOutput($sformatf("t1_valid_c%0d", i), m_valid, (i >= 2 && i <= 4) ? 1 : 0);
            checkOutput($sformatf("t1_busy_c%0d", i), busy, (i >= 1 && i <= 4) ? 1 : 0);
            @(posedge clk); #1;
        end
        waitDrain(20);

        // Test 2: backpressure fills exactly two slots
        @(posedge clk); #1;
        m_ready = 1'b0;
        p0 = popCount;
        for (int i = 0; i < 5; i++) applyStimulus(8'h41 + 8'(i));
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t2_pops", popCount - p0, 2);
        checkOutput("t2_valid", m_valid, 1);
        checkOutput("t2_head", m_data, 8'h41);
        checkOutput("t2_rd_en", fifo_rd_en, 0);
        checkOutput("t2_busy", busy, 1);
        m_ready = 1'b1;
        waitDrain(40);

        // Test 3: sixteen bytes at full rate
        @(posedge clk); #1;
        win = 0;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid && m_ready && i >= 2 && i <= 17) win++;
            if (i <= 15) checkOutput($sformatf("t3_rd_en_c%0d", i), fifo_rd_en, 1);
            @(posedge clk); #1;
        end
        checkOutput("t3_accepts", win, 16);
        waitDrain(20);

        // Test 4: m_ready toggling every cycle
        for (int i = 0; i < 12; i++) applyStimulus(8'h50 + 8'(i));
        for (int i = 0; i < 40; i++) begin
            m_ready = (i % 2 == 0);
            @(negedge clk);
            checkOutput("t4_outstanding_le2", ((popCount - acceptTotal) <= 2) ? 1 : 0, 1);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        waitDrain(40);

        // Test 5: ena dropped for three cycles mid-stream
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) applyStimulus(8'h60 + 8'(i));
        repeat (4) begin
            @(posedge clk); #1;
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_rd_en_off_c%0d", i), fifo_rd_en, 0);
            @(posedge clk); #1;
        end
        ena = 1'b1;
        waitDrain(60);

        // Test 6: asynchronous reset with a full buffer, then 300 accepts
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(8'h70 + 8'(i));
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t6_valid_before", m_valid, 1);
        checkOutput("t6_head_before", m_data, 8'h70);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", m_valid, 0);
        checkOutput("t6_async_busy", busy, 0);
        checkOutput("t6_async_rd_en", fifo_rd_en, 0);
        checkOutput("t6_async_data", m_data, 8'h00);
        expQ.delete();
        for (int k = rdPtr; k < wrPtr; k++) expQ.push_back(mem[k]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("t6_rd_en_in_reset", fifo_rd_en, 0);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 297; k++) applyStimulus(8'(k));
        waitDrain(400);
        checkOutput("t6_accepts", acceptSinceReset, 300);
`ifdef FIFO_RD_CNT_EN
        checkOutput("t6_pop_count", pop_count, 8'd44);
`else
        checkOutput("t6_pop_count", pop_count, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
